// File: rtl/led_display_row_driver.sv
// HUB75 row driver: shifts one RGB row per handshake, then blanks, latches
// and displays it while the previous row stays lit during the next shift.
module led_display_row_driver #(
    parameter int SYS_CLK_FREQ       = 100_000_000,
    parameter int BCLK_FREQ          = 21_000_000,
    parameter int NUM_COL_PIXELS     = 64,
    parameter int NUM_ROW_PIXELS     = 32,
    parameter int BLANK_CYCLES       = 4,
    parameter int LATCH_CYCLES       = 2,
    parameter int MIN_DISPLAY_CYCLES = 256,
    localparam int GL_RGB_ROW_W      = 6 * NUM_COL_PIXELS,
    localparam int ADDR_W            = $clog2(NUM_ROW_PIXELS / 2)
) (
    input  logic                    clk_in,
    input  logic                    n_reset_in,
    input  logic [GL_RGB_ROW_W-1:0] row_in,
    input  logic [ADDR_W-1:0]       row_address_in,
    input  logic                    row_valid_in,
    output logic                    row_ready_out,
    output logic                    bclk_out,
    output logic [2:0]              rgb_top_out,
    output logic [2:0]              rgb_bot_out,
    output logic                    latch_out,
    output logic                    oe_n_out,
    output logic [ADDR_W-1:0]       addr_out
);

    localparam int DIV_RAW  = SYS_CLK_FREQ / (2 * BCLK_FREQ);
    localparam int BCLK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PH_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W    = $clog2(NUM_COL_PIXELS);
    localparam int BL_MAX   = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int DW_MAX   = (BL_MAX > MIN_DISPLAY_CYCLES) ? BL_MAX : MIN_DISPLAY_CYCLES;
    localparam int DW_W     = (DW_MAX > 1) ? $clog2(DW_MAX) : 1;

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_COL   = BIT_W'(NUM_COL_PIXELS - 1);
    localparam logic [DW_W-1:0]  BLANK_LAST = DW_W'(BLANK_CYCLES - 1);
    localparam logic [DW_W-1:0]  LATCH_LAST = DW_W'(LATCH_CYCLES - 1);
    localparam logic [DW_W-1:0]  DISP_LAST  = DW_W'(MIN_DISPLAY_CYCLES - 1);

    typedef struct packed {
        logic [NUM_COL_PIXELS-1:0] red;
        logic [NUM_COL_PIXELS-1:0] green;
        logic [NUM_COL_PIXELS-1:0] blue;
    } rgb_plane_t;

    typedef struct packed {
        rgb_plane_t top;
        rgb_plane_t bot;
    } rgb_row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    function automatic logic [2:0] pick(input rgb_plane_t p, input logic [BIT_W-1:0] c);
        return {p.blue[c], p.green[c], p.red[c]};
    endfunction

    rgb_row_t          w_row;
    rgb_row_t          r_row;
    logic [ADDR_W-1:0] r_addr;
    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic [BIT_W-1:0]  r_bit;
    logic [DW_W-1:0]   r_dwell;
    logic              r_high;
    logic              r_lit;
    logic              r_ready;
    logic              r_bclk;
    logic [2:0]        r_rgb_top;
    logic [2:0]        r_rgb_bot;
    logic              r_latch;
    logic              r_oe_n;
    logic [ADDR_W-1:0] r_addr_out;

    assign w_row = rgb_row_t'(row_in);

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_addr     <= '0;
            r_phase    <= '0;
            r_bit      <= LAST_COL;
            r_dwell    <= '0;
            r_high     <= 1'b0;
            r_lit      <= 1'b0;
            r_ready    <= 1'b0;
            r_bclk     <= 1'b0;
            r_rgb_top  <= '0;
            r_rgb_bot  <= '0;
            r_latch    <= 1'b0;
            r_oe_n     <= 1'b1;
            r_addr_out <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_oe_n <= !r_lit;
                    if (row_valid_in && r_ready) begin
                        r_row     <= w_row;
                        r_addr    <= row_address_in;
                        r_ready   <= 1'b0;
                        r_phase   <= '0;
                        r_high    <= 1'b0;
                        r_bit     <= LAST_COL;
                        r_rgb_top <= pick(w_row.top, LAST_COL);
                        r_rgb_bot <= pick(w_row.bot, LAST_COL);
                        r_state   <= S_SHIFT;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_oe_n <= !r_lit;
                    if (r_phase != PH_LAST) begin
                        r_phase <= r_phase + 1'b1;
                    end else if (!r_high) begin
                        r_phase <= '0;
                        r_high  <= 1'b1;
                        r_bclk  <= 1'b1;
                    end else begin
                        r_phase <= '0;
                        r_high  <= 1'b0;
                        r_bclk  <= 1'b0;
                        if (r_bit == '0) begin
                            // Blank before the latch so the address moves while dark
                            r_bit   <= LAST_COL;
                            r_oe_n  <= 1'b1;
                            r_dwell <= '0;
                            r_state <= S_BLANK;
                        end else begin
                            r_bit     <= r_bit - 1'b1;
                            r_rgb_top <= pick(r_row.top, r_bit - 1'b1);
                            r_rgb_bot <= pick(r_row.bot, r_bit - 1'b1);
                        end
                    end
                end
                S_BLANK: begin
                    if (r_dwell == BLANK_LAST) begin
                        r_dwell    <= '0;
                        r_latch    <= 1'b1;
                        r_addr_out <= r_addr;
                        r_state    <= S_LATCH;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_dwell == LATCH_LAST) begin
                        r_dwell <= '0;
                        r_latch <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_lit   <= 1'b1;
                        r_state <= S_DISPLAY;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                S_DISPLAY: begin
                    if (r_dwell == DISP_LAST) begin
                        r_dwell <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign row_ready_out = r_ready;
    assign bclk_out      = r_bclk;
    assign rgb_top_out   = r_rgb_top;
    assign rgb_bot_out   = r_rgb_bot;
    assign latch_out     = r_latch;
    assign oe_n_out      = r_oe_n;
    assign addr_out      = r_addr_out;

endmodule
